code_display: RTL

CODE_DISPLAY -- requirements
Module: code_display

---
 rtl/code_display_pkg.sv | 39 +++
 rtl/code_display_if.sv | 28 ++
 rtl/code_display_seg7_decode.sv | 13 +
 rtl/code_display.sv | 138 +++++++++++++
 4 files changed

// File: rtl/code_display_pkg.sv
// Shared constants, 7-segment table and key classification for the code entry display.
package code_display_pkg;

  localparam logic [3:0] GLYPH_DASH  = 4'hA;
  localparam logic [3:0] GLYPH_BLANK = 4'hB;
  localparam logic [4:0] KEY_BS      = 5'd10;
  localparam logic [4:0] KEY_CLR     = 5'd11;
  localparam logic [4:0] KEY_MAX_DIG = 5'd9;

  // Segment bits are {a,b,c,d,e,f,g,dp}, active high; A is the dash, B..F are blank.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {
    KC_NONE  = 2'd0,
    KC_DIGIT = 2'd1,
    KC_BS    = 2'd2,
    KC_CLR   = 2'd3
  } key_class_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] value;
  } key_evt_t;

  function automatic key_class_e classify_key(input key_evt_t key);
    key_class_e kc;
    kc = KC_NONE;
    if (key.valid) begin
      if (key.value <= KEY_MAX_DIG)  kc = KC_DIGIT;
      else if (key.value == KEY_BS)  kc = KC_BS;
      else if (key.value == KEY_CLR) kc = KC_CLR;
    end
    return kc;
  endfunction

endpackage

// File: rtl/code_display_if.sv
// Keypad, entry-status and display signals of code_display.
interface code_display_if #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned CW     = $clog2(DIGITS + 1)
) ();

  logic                  key_valid;
  logic [4:0]            key_value;
  logic                  clear;
  logic                  mask_en;
  logic [4*DIGITS-1:0]   code;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  done;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;

  modport master (
    output key_valid, key_value, clear, mask_en,
    input  code, count, full, done, seg, an
  );

  modport slave (
    input  key_valid, key_value, clear, mask_en,
    output code, count, full, done, seg, an
  );

endinterface

// File: rtl/code_display_seg7_decode.sv
// Glyph to active-high 7-segment pattern lookup.
module seg7_decode
  import code_display_pkg::*;
(
  input  logic [3:0] glyph,
  output logic [7:0] seg_c
);

  always_comb begin
    seg_c = SEG_TABLE[glyph];
  end

endmodule

// File: rtl/code_display.sv
// Code entry buffer with multiplexed 7-segment display scan and optional masking.
module code_display
  import code_display_pkg::*;
#(
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned CW       = $clog2(DIGITS + 1)
) (
  input  logic           clk,
  input  logic           reset,
  code_display_if.slave  bus
);

  localparam int unsigned CODE_W = 4 * DIGITS;
  localparam int unsigned PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW     = $clog2(DIGITS);

  logic [1:0]         rst_sync;
  logic               rst_int_n;

  logic [CODE_W-1:0]  code_q, code_n;
  logic [CW-1:0]      count_q, count_n;
  logic               full_q, full_n;
  logic               done_q, done_n;
  logic [PW-1:0]      presc_q, presc_n;
  logic [IW-1:0]      idx_q, idx_n;
  logic [DIGITS-1:0]  an_q, an_n;
  logic [7:0]         seg_q, seg_n;

  key_evt_t           key;
  key_class_e         kc;
  logic               clr_hit, dig_wr, bs_wr;
  int unsigned        wr_pos, bs_pos;

  logic               tick;
  logic               entered;
  logic [3:0]         nibble;
  logic [3:0]         glyph_c;
  logic [7:0]         seg_c;

  // Assertion is immediate; release reaches the state registers two edges later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      code_q  <= {DIGITS{GLYPH_DASH}};
      count_q <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= 8'h00;
    end else begin
      code_q  <= code_n;
      count_q <= count_n;
      full_q  <= full_n;
      done_q  <= done_n;
      presc_q <= presc_n;
      idx_q   <= idx_n;
      an_q    <= an_n;
      seg_q   <= seg_n;
    end
  end

  assign key = '{valid: bus.key_valid, value: bus.key_value};
  assign kc  = classify_key(key);

  // Entry buffer: clear beats any simultaneous key; digits fill from the MS nibble.
  always_comb begin
    code_n  = code_q;
    count_n = count_q;
    done_n  = 1'b0;
    clr_hit = bus.clear || (kc == KC_CLR);
    dig_wr  = !bus.clear && (kc == KC_DIGIT) && (count_q != CW'(DIGITS));
    bs_wr   = !bus.clear && (kc == KC_BS) && (count_q != '0);
    wr_pos  = DIGITS - 1 - 32'(count_q);
    bs_pos  = DIGITS - 32'(count_q);

    if (clr_hit) begin
      code_n  = {DIGITS{GLYPH_DASH}};
      count_n = '0;
    end else if (dig_wr) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (i == wr_pos) code_n[4*i +: 4] = key.value[3:0];
      end
      count_n = count_q + CW'(1);
      done_n  = (count_q == CW'(DIGITS - 1));
    end else if (bs_wr) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (i == bs_pos) code_n[4*i +: 4] = GLYPH_DASH;
      end
      count_n = count_q - CW'(1);
    end

    full_n = (count_n == CW'(DIGITS));
  end

  // Glyph for the position currently indexed by the scan.
  always_comb begin
    entered = (32'(idx_q) + 32'(count_q)) >= DIGITS;
    nibble  = code_q[{idx_q, 2'b00} +: 4];
    if (bus.mask_en) glyph_c = entered ? GLYPH_DASH : GLYPH_BLANK;
    else             glyph_c = entered ? nibble : GLYPH_DASH;
  end

  seg7_decode u_seg7_decode (
    .glyph (glyph_c),
    .seg_c (seg_c)
  );

  // Scan: select and segments load together on the prescaler terminal count.
  always_comb begin
    tick    = (presc_q == PW'(SCAN_DIV - 1));
    presc_n = tick ? '0 : presc_q + PW'(1);
    idx_n   = idx_q;
    an_n    = an_q;
    seg_n   = seg_q;
    if (tick) begin
      idx_n = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      an_n  = ~(DIGITS'(1) << idx_q);
      seg_n = seg_c;
    end
  end

  assign bus.code  = code_q;
  assign bus.count = count_q;
  assign bus.full  = full_q;
  assign bus.done  = done_q;
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;

endmodule
